// File: rtl/calc_sequencer.sv
// calc_sequencer: operand/operation entry FSM that latches an arithmetic unit's result for display.
// Optional macro DIV_ZERO_CHECK_EN flags divide-by-zero on errorLed and shows 8'hFF.
module calc_sequencer (
  input  logic       clk,
  input  logic       resetN,
  input  logic       enter,
  input  logic       clear,
  input  logic [3:0] sw,
  input  logic [7:0] result,
  input  logic       resultOverflow,
  output logic [3:0] x,
  output logic [3:0] y,
  output logic [3:0] ynot,
  output logic [7:0] z,
  output logic [1:0] operation,
  output logic [7:0] displayValue,
  output logic       overflowLed,
  output logic       errorLed,
  output logic [2:0] stateCode,
  output logic       done
);
  typedef enum logic [2:0] {
    WAIT_X  = 3'd0,
    WAIT_Y  = 3'd1,
    WAIT_OP = 3'd2,
    EXEC    = 3'd3,
    SHOW    = 3'd4
  } state_t;
  state_t     state_q, state_d;
  logic [3:0] x_q, x_d, y_q, y_d, ynot_q, ynot_d;
  logic [1:0] op_q, op_d;
  logic [7:0] disp_q, disp_d;
  logic       ovf_q, ovf_d, err_q, err_d, done_q, done_d;
  logic       enter_q, armed_q, press;
  // armed_q masks the first edge after reset so a button held through release is not a press
  assign press = enter && !enter_q && armed_q;
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    ynot_d  = ynot_q;
    op_d    = op_q;
    disp_d  = disp_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    done_d  = 1'b0;
    if (clear) state_d = WAIT_X;
    else begin
      case (state_q)
        WAIT_X:  if (press) begin x_d = sw; state_d = WAIT_Y; end
        WAIT_Y:  if (press) begin y_d = sw; ynot_d = ~sw + 4'd1; state_d = WAIT_OP; end
        WAIT_OP: if (press) begin op_d = sw[1:0]; state_d = EXEC; end
        EXEC: begin
          state_d = SHOW;
          done_d  = 1'b1;
          disp_d  = result;
          ovf_d   = !op_q[1] && resultOverflow;
          err_d   = 1'b0;
`ifdef DIV_ZERO_CHECK_EN
          if (op_q == 2'b11 && y_q == 4'd0) begin
            disp_d = 8'hFF;
            ovf_d  = 1'b0;
            err_d  = 1'b1;
          end
`endif
        end
        SHOW:    if (press) state_d = WAIT_X;
        default: state_d = WAIT_X;
      endcase
    end
  end
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= WAIT_X;
      x_q     <= '0;
      y_q     <= '0;
      ynot_q  <= '0;
      op_q    <= '0;
      disp_q  <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      enter_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      ynot_q  <= ynot_d;
      op_q    <= op_d;
      disp_q  <= disp_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
      done_q  <= done_d;
      enter_q <= enter;
      armed_q <= 1'b1;
    end
  end
  assign x            = x_q;
  assign y            = y_q;
  assign ynot         = ynot_q;
  assign z            = {x_q, y_q};
  assign operation    = op_q;
  assign displayValue = disp_q;
  assign overflowLed  = ovf_q;
  assign errorLed     = err_q;
  assign stateCode    = state_q;
  assign done         = done_q;
endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: directed bench with a scoreboard of expected latched results.
module tb_calc_sequencer;
  logic       clk, resetN, enter, clear, resultOverflow;
  logic [3:0] sw;
  logic [7:0] result;
  logic [3:0] x, y, ynot;
  logic [7:0] z, displayValue;
  logic [1:0] operation;
  logic       overflowLed, errorLed, done;
  logic [2:0] stateCode;
  int         vectors = 0;
  int         errs = 0;
  logic [9:0] sb[$];

  calc_sequencer dut (
    .clk(clk), .resetN(resetN), .enter(enter), .clear(clear), .sw(sw),
    .result(result), .resultOverflow(resultOverflow), .x(x), .y(y), .ynot(ynot),
    .z(z), .operation(operation), .displayValue(displayValue),
    .overflowLed(overflowLed), .errorLed(errorLed), .stateCode(stateCode), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] v);
    sw = v;
    enter = 1'b1;
    cyc();
    enter = 1'b0;
  endtask

  task automatic operand(input logic [3:0] v);
    press(v);
    cyc();
  endtask

  task automatic do_op(input logic [1:0] op, input logic [7:0] res, input logic ovf_in,
                       input logic [7:0] exp_d, input logic exp_o, input logic exp_e);
    logic [9:0] e;
    int n;
    result = res;
    resultOverflow = ovf_in;
    sb.push_back({exp_d, exp_o, exp_e});
    press({2'b00, op});
    chk("exec_state", 32'(stateCode), 32'd3);
    chk("op_latch", 32'(operation), 32'(op));
    n = 0;
    while (!done && n < 4) begin
      cyc();
      n++;
    end
    chk("done_latency", n, 1);
    e = sb.size() > 0 ? sb.pop_front() : 10'h3FF;
    chk("display", 32'(displayValue), 32'(e[9:2]));
    chk("overflow", 32'(overflowLed), 32'(e[1]));
    chk("error", 32'(errorLed), 32'(e[0]));
    cyc();
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("show_state", 32'(stateCode), 32'd4);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_state"}, 32'(stateCode), 0);
    chk({tag, "_x"}, 32'(x), 0);
    chk({tag, "_y"}, 32'(y), 0);
    chk({tag, "_ynot"}, 32'(ynot), 0);
    chk({tag, "_z"}, 32'(z), 0);
    chk({tag, "_op"}, 32'(operation), 0);
    chk({tag, "_disp"}, 32'(displayValue), 0);
    chk({tag, "_ovf"}, 32'(overflowLed), 0);
    chk({tag, "_err"}, 32'(errorLed), 0);
    chk({tag, "_done"}, 32'(done), 0);
  endtask

  initial begin
    logic [7:0] dz_disp;
    logic       dz_err;
    resetN = 1'b0;
    enter = 1'b1;
    clear = 1'b0;
    sw = 4'd7;
    result = 8'h00;
    resultOverflow = 1'b0;
    #23;
    chk_all_zero("reset");
    // button already held when reset releases
    cyc();
    resetN = 1'b1;
    repeat (3) cyc();
    chk("held_at_release", 32'(stateCode), 0);
    enter = 1'b0;
    cyc();
    operand(4'd3);
    chk("x_latch", 32'(x), 32'h3);
    chk("wait_y", 32'(stateCode), 32'd1);
    operand(4'd5);
    chk("y_latch", 32'(y), 32'h5);
    chk("ynot_latch", 32'(ynot), 32'hB);
    chk("z_concat", 32'(z), 32'h35);
    chk("wait_op", 32'(stateCode), 32'd2);
    do_op(2'b00, 8'h08, 1'b0, 8'h08, 1'b0, 1'b0);
    press(4'd0);
    cyc();
    chk("show_to_wait_x", 32'(stateCode), 0);
    chk("display_held", 32'(displayValue), 32'h08);
    operand(4'd9);
    operand(4'd9);
    do_op(2'b00, 8'h12, 1'b1, 8'h12, 1'b1, 1'b0);
    press(4'd0);
    cyc();
    operand(4'd9);
    operand(4'd9);
    do_op(2'b10, 8'h51, 1'b1, 8'h51, 1'b0, 1'b0);
    press(4'd0);
    cyc();
    sw = 4'd6;
    enter = 1'b1;
    repeat (20) cyc();
    chk("held_once_state", 32'(stateCode), 32'd1);
    chk("held_once_x", 32'(x), 32'h6);
    enter = 1'b0;
    cyc();
    sw = 4'd7;
    enter = 1'b1;
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    enter = 1'b0;
    chk("clear_wins_state", 32'(stateCode), 0);
    chk("clear_wins_y", 32'(y), 32'h9);
    cyc();
    operand(4'd1);
    operand(4'd2);
    result = 8'h77;
    press(4'd0);
    chk("pre_clear_exec", 32'(stateCode), 32'd3);
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    chk("exec_clear_done", 32'(done), 0);
    chk("exec_clear_state", 32'(stateCode), 0);
    chk("exec_clear_disp", 32'(displayValue), 32'h51);
    cyc();
    chk("exec_clear_done2", 32'(done), 0);
    operand(4'd4);
    operand(4'd0);
    chk("ynot_zero", 32'(ynot), 0);
`ifdef DIV_ZERO_CHECK_EN
    dz_disp = 8'hFF;
    dz_err = 1'b1;
`else
    dz_disp = 8'h33;
    dz_err = 1'b0;
`endif
    do_op(2'b11, 8'h33, 1'b1, dz_disp, 1'b0, dz_err);
    press(4'd0);
    cyc();
    operand(4'd2);
    operand(4'd1);
    do_op(2'b00, 8'h2A, 1'b0, 8'h2A, 1'b0, 1'b0);
    #2;
    resetN = 1'b0;
    #2;
    chk_all_zero("async_reset");
    cyc();
    resetN = 1'b1;
    cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
